// File: rtl/mmio_arbiter_pkg.sv
// Shared MMIO definitions: register map, arbiter FSM encodings and master ids.
package mmio_arbiter_pkg;

    localparam logic [31:0] MMIO_LED_ADDR = 32'h4000_0000;
    localparam logic [31:0] MMIO_SW_ADDR  = 32'h4000_0004;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

endpackage

// File: rtl/mmio_arbiter_if.sv
// Master-side bus of the MMIO arbiter: CPU (m0) and debug/loader (m1) request ports.
// Handshake: a master raises req with stable addr/wdata/we/lock and holds them until its
// rvalid pulse; gnt marks ownership, rvalid marks completion with rdata valid.
interface mmio_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic              m0_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_rvalid;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_rvalid;
    logic [DATA_W-1:0] m1_rdata;

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata
    );

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata
    );
endinterface

// File: rtl/mmio_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; an active lock restricts the pick to the lock owner.
module mmio_rr_pick2
    import mmio_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    input  logic       lock_valid,
    input  logic       lock_owner,
    output logic       winner,
    output logic       valid
);
    always_comb begin
        winner = M_CPU;
        valid  = 1'b0;
        if (lock_valid) begin
            winner = lock_owner;
            valid  = req[lock_owner];
        end else begin
            valid = |req;
            if (req == 2'b11) begin
                winner = ~last_served;
            end else if (req[1]) begin
                winner = M_DBG;
            end else begin
                winner = M_CPU;
            end
        end
    end
endmodule

// File: rtl/mmio_arbiter.sv
// Two-master MMIO arbiter: one registered slave access per grant, round-robin between masters.
// Optional bus lock for atomic read-modify-write is built when MMIO_ARB_LOCK_EN is defined.
module mmio_arbiter
    import mmio_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mmio_arbiter_if.slave     bus,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    output logic              s_we,
    input  logic [DATA_W-1:0] s_rdata,
    output arb_state_e        dbg_state
);
    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_served_q, last_served_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              lock_valid;
    logic              lock_owner;
    logic              winner;
    logic              pick_valid;

`ifdef MMIO_ARB_LOCK_EN
    logic lock_q, lock_d;
    logic lock_valid_q, lock_valid_d;
    logic lock_owner_q, lock_owner_d;
    assign lock_valid = lock_valid_q;
    assign lock_owner = lock_owner_q;
`else
    logic unused_lock;
    assign unused_lock = bus.m0_lock ^ bus.m1_lock;
    assign lock_valid  = 1'b0;
    assign lock_owner  = M_CPU;
`endif

    mmio_rr_pick2 u_pick (
        .req         ({bus.m1_req, bus.m0_req}),
        .last_served (last_served_q),
        .lock_valid  (lock_valid),
        .lock_owner  (lock_owner),
        .winner      (winner),
        .valid       (pick_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            owner_q       <= M_CPU;
            last_served_q <= M_DBG;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_served_q <= last_served_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
        end
    end

`ifdef MMIO_ARB_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_valid_q <= 1'b0;
            lock_owner_q <= M_CPU;
        end else begin
            lock_q       <= lock_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
        end
    end
`endif

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_served_d = last_served_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
`ifdef MMIO_ARB_LOCK_EN
        lock_d        = lock_q;
        lock_valid_d  = lock_valid_q;
        lock_owner_d  = lock_owner_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_ACCESS;
                    owner_d = winner;
                    addr_d  = winner ? bus.m1_addr  : bus.m0_addr;
                    wdata_d = winner ? bus.m1_wdata : bus.m0_wdata;
                    we_d    = winner ? bus.m1_we    : bus.m0_we;
`ifdef MMIO_ARB_LOCK_EN
                    lock_d = winner ? bus.m1_lock : bus.m0_lock;
                    if (lock_d) begin
                        lock_valid_d = 1'b1;
                        lock_owner_d = winner;
                    end
`endif
                end
            end
            ARB_ACCESS: begin
                // Read data is captured for writes too; the slave returns the pre-write value.
                state_d = ARB_RESP;
                if (owner_q == M_DBG) begin
                    rdata1_d = s_rdata;
                end else begin
                    rdata0_d = s_rdata;
                end
            end
            ARB_RESP: begin
                state_d       = ARB_IDLE;
                last_served_d = owner_q;
`ifdef MMIO_ARB_LOCK_EN
                if (lock_valid_q && (lock_owner_q == owner_q) && !lock_q) begin
                    lock_valid_d = 1'b0;
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign s_addr        = (state_q == ARB_ACCESS) ? addr_q  : '0;
    assign s_wdata       = (state_q == ARB_ACCESS) ? wdata_q : '0;
    assign s_we          = (state_q == ARB_ACCESS) && we_q;
    assign bus.m0_gnt    = (state_q != ARB_IDLE) && (owner_q == M_CPU);
    assign bus.m1_gnt    = (state_q != ARB_IDLE) && (owner_q == M_DBG);
    assign bus.m0_rvalid = (state_q == ARB_RESP) && (owner_q == M_CPU);
    assign bus.m1_rvalid = (state_q == ARB_RESP) && (owner_q == M_DBG);
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_mmio_arbiter.sv
// Self-checking bench for mmio_arbiter with a small LED/switch slave model.
module tb_mmio_arbiter;
    import mmio_arbiter_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  s_addr;
    logic [W-1:0]  s_wdata;
    logic          s_we;
    logic [W-1:0]  s_rdata;
    arb_state_e    dbg_state;

    logic [W-1:0]  leds = '0;
    logic [W-1:0]  switches = '0;
    logic [W-1:0]  led_ref = '0;
    logic [W-1:0]  exp_q0[$];
    logic [W-1:0]  exp_q1[$];

    int vectors = 0;
    int miscompares = 0;
    int we_cnt = 0;
    logic [W-1:0] we_data = '0;
    bit other_seen;

    mmio_arbiter_if #(.ADDR_W(W), .DATA_W(W)) bus ();

    mmio_arbiter #(.ADDR_W(W), .DATA_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_we      (s_we),
        .s_rdata   (s_rdata),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // slave model: LED register and switch input, unmapped reads return 0
    always_comb begin
        if (s_addr == MMIO_LED_ADDR)     s_rdata = leds;
        else if (s_addr == MMIO_SW_ADDR) s_rdata = switches;
        else                             s_rdata = '0;
    end

    always @(posedge clk) begin
        if (s_we && s_addr == MMIO_LED_ADDR) leds <= s_wdata;
    end

    always @(negedge clk) begin
        if (s_we) begin
            we_cnt  = we_cnt + 1;
            we_data = s_wdata;
        end
    end

    // driver tasks
    task automatic issue(input int m, input bit we, input logic [W-1:0] addr,
                         input logic [W-1:0] wdata, input bit lock);
        logic [W-1:0] exp;
        if (addr == MMIO_LED_ADDR)     exp = led_ref;
        else if (addr == MMIO_SW_ADDR) exp = switches;
        else                           exp = '0;
        if (we && addr == MMIO_LED_ADDR) led_ref = wdata;
        if (m == 0) begin
            bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr;
            bus.m0_wdata = wdata; bus.m0_lock = lock;
            exp_q0.push_back(exp);
        end else begin
            bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr;
            bus.m1_wdata = wdata; bus.m1_lock = lock;
            exp_q1.push_back(exp);
        end
    endtask

    // Waits (from a negedge) for master m's rvalid, checks rdata and optionally latency.
    task automatic wait_done(input int m, input bit drop, input int exp_lat);
        int lat;
        bit seen;
        logic [W-1:0] got;
        logic [W-1:0] exp;
        lat = 0;
        seen = 1'b0;
        other_seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (m == 0) begin
                seen = bus.m0_rvalid;
                if (bus.m1_gnt || bus.m1_rvalid) other_seen = 1'b1;
            end else begin
                seen = bus.m1_rvalid;
                if (bus.m0_gnt || bus.m0_rvalid) other_seen = 1'b1;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL m%0d_rvalid_timeout: no rvalid within %0d cycles, required one", m, lat);
            if (m == 0) exp_q0.delete(); else exp_q1.delete();
        end else begin
            if (m == 0) begin exp = exp_q0.pop_front(); got = bus.m0_rdata; end
            else        begin exp = exp_q1.pop_front(); got = bus.m1_rdata; end
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL m%0d_rdata: got %h required %h", m, got, exp);
            end
            if (exp_lat > 0) begin
                vectors++;
                if (lat !== exp_lat) begin
                    miscompares++;
                    $display("FAIL m%0d_latency: got %0d required %0d", m, lat, exp_lat);
                end
            end
        end
        if (drop) begin
            if (m == 0) bus.m0_req = 1'b0; else bus.m1_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // scenarios
    task automatic test_reset();
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_lock = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (dbg_state !== ARB_IDLE) begin
            miscompares++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ARB_IDLE);
        end
        vectors++;
        if ({bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, s_we} !== 5'b0) begin
            miscompares++; $display("FAIL reset_ctrl: gnt/rvalid/s_we got %b required 00000",
                {bus.m0_gnt, bus.m1_gnt, bus.m0_rvalid, bus.m1_rvalid, s_we});
        end
        vectors++;
        if ({s_addr, s_wdata, bus.m0_rdata, bus.m1_rdata} !== '0) begin
            miscompares++; $display("FAIL reset_data: s_addr %h s_wdata %h rdata %h/%h required 0",
                s_addr, s_wdata, bus.m0_rdata, bus.m1_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cpu_write();
        @(negedge clk);
        we_cnt = 0;
        issue(0, 1'b1, MMIO_LED_ADDR, 32'h155, 1'b0);
        wait_done(0, 1'b1, 2);
        vectors++;
        if (we_cnt !== 1) begin
            miscompares++; $display("FAIL s_we_cycles: got %0d required 1", we_cnt);
        end
        vectors++;
        if (we_data !== 32'h155) begin
            miscompares++; $display("FAIL s_wdata: got %h required %h", we_data, 32'h155);
        end
        vectors++;
        if (leds !== 32'h155) begin
            miscompares++; $display("FAIL leds_after_write: got %h required %h", leds, 32'h155);
        end
    endtask

    task automatic test_dbg_read();
        switches = 32'h2AA;
        @(negedge clk);
        issue(1, 1'b0, MMIO_SW_ADDR, '0, 1'b0);
        wait_done(1, 1'b1, 2);
        vectors++;
        if (other_seen !== 1'b0) begin
            miscompares++; $display("FAIL m0_gnt_during_m1: got 1 required 0");
        end
        @(negedge clk);
        issue(0, 1'b0, 32'h4000_0010, '0, 1'b0);
        wait_done(0, 1'b1, 2);
        @(negedge clk);
        issue(0, 1'b0, MMIO_LED_ADDR, '0, 1'b0);
        wait_done(0, 1'b1, 2);
    endtask

    task automatic test_tie();
        do_reset();
        issue(0, 1'b0, MMIO_LED_ADDR, '0, 1'b0);
        issue(1, 1'b0, MMIO_SW_ADDR, '0, 1'b0);
        wait_done(0, 1'b1, 2);
        wait_done(1, 1'b1, 3);
        @(negedge clk);
        issue(0, 1'b0, MMIO_SW_ADDR, '0, 1'b0);
        issue(1, 1'b0, MMIO_LED_ADDR, '0, 1'b0);
        wait_done(0, 1'b1, 2);
        wait_done(1, 1'b1, 3);
        @(negedge clk);
        issue(0, 1'b0, MMIO_LED_ADDR, '0, 1'b0);
        wait_done(0, 1'b1, 2);
        @(negedge clk);
        issue(0, 1'b0, MMIO_LED_ADDR, '0, 1'b0);
        issue(1, 1'b0, MMIO_SW_ADDR, '0, 1'b0);
        wait_done(1, 1'b1, 2);
        wait_done(0, 1'b1, 3);
    endtask

    task automatic test_reset_in_access();
        logic [W-1:0] saved;
        int rv;
        saved = led_ref;
        @(negedge clk);
        issue(0, 1'b1, MMIO_LED_ADDR, 32'h3FF, 1'b0);
        @(negedge clk);
        vectors++;
        if (dbg_state !== ARB_ACCESS || s_we !== 1'b1) begin
            miscompares++; $display("FAIL access_before_reset: state %0d s_we %b required %0d 1",
                dbg_state, s_we, ARB_ACCESS);
        end
        #1 reset = 1'b1;
        #1;
        vectors++;
        if (dbg_state !== ARB_IDLE || {s_we, s_addr, s_wdata, bus.m0_gnt, bus.m0_rvalid, bus.m0_rdata} !== '0) begin
            miscompares++; $display("FAIL async_reset_outputs: state %0d s_we %b s_addr %h s_wdata %h gnt %b rdata %h required all 0",
                dbg_state, s_we, s_addr, s_wdata, bus.m0_gnt, bus.m0_rdata);
        end
        bus.m0_req = 1'b0;
        exp_q0.delete();
        led_ref = saved;
        @(negedge clk);
        reset = 1'b0;
        rv = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.m0_rvalid) rv++;
        end
        vectors++;
        if (rv !== 0) begin
            miscompares++; $display("FAIL rvalid_after_reset: got %0d pulses required 0", rv);
        end
        vectors++;
        if (leds !== saved) begin
            miscompares++; $display("FAIL leds_after_reset: got %h required %h", leds, saved);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue(0, 1'b0, MMIO_LED_ADDR, '0, 1'b0);
        wait_done(0, 1'b0, 2);
        issue(0, 1'b0, MMIO_LED_ADDR, '0, 1'b0);
        wait_done(0, 1'b1, 3);
    endtask

`ifdef MMIO_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        issue(0, 1'b0, MMIO_LED_ADDR, '0, 1'b1);
        issue(1, 1'b0, MMIO_SW_ADDR, '0, 1'b0);
        wait_done(0, 1'b0, 2);
        vectors++;
        if (other_seen !== 1'b0) begin
            miscompares++; $display("FAIL lock_m1_gnt_first: got 1 required 0");
        end
        issue(0, 1'b1, MMIO_LED_ADDR, 32'h001, 1'b0);
        wait_done(0, 1'b1, 3);
        vectors++;
        if (other_seen !== 1'b0) begin
            miscompares++; $display("FAIL lock_m1_blocked: got 1 required 0");
        end
        wait_done(1, 1'b1, 3);
        vectors++;
        if (leds !== 32'h001) begin
            miscompares++; $display("FAIL lock_led_write: got %h required %h", leds, 32'h001);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_cpu_write();
        test_dbg_read();
        test_tie();
        test_reset_in_access();
        test_back_to_back();
`ifdef MMIO_ARB_LOCK_EN
        test_lock();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
